// File: rtl/sub_shift_stage.sv
// AES SubBytes + ShiftRows round stage.
// LANES shared S-boxes substitute the state in place over 16/LANES cycles.
module sub_shift_stage #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    generate
        if (!(LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_shift_stage: LANES must be 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [127:0]    st;
    logic [127:0]    st_nxt;
    logic [7:0]      sin  [LANES];
    logic [7:0]      sout [LANES];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the field inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] y;
        y = a;
        for (int i = 0; i < 6; i++) begin
            y = gmul(gmul(y, y), a);
        end
        return gmul(y, y);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = ginv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign sout[j] = sbox(sin[j]);
    end

    always_comb begin
        st_nxt = st;
        for (int j = 0; j < LANES; j++) begin
            sin[j] = st[127-8*(LANES*int'(cnt)+j) -: 8];
            st_nxt[127-8*(LANES*int'(cnt)+j) -: 8] = sout[j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            st        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st       <= in_data;
                        cnt      <= '0;
                        state    <= SUB;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SUB: begin
                    st <= st_nxt;
                    if (cnt == CW'(NCYC - 1)) begin
                        out_data  <= shift_rows(st_nxt);
                        out_valid <= 1'b1;
                        state     <= DONE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Scoreboard bench for sub_shift_stage against a table-built AES model.
// Directed FIPS/ordering/backpressure/reset cases, then random traffic.
module tb_sub_shift_stage;

    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_data;

    sub_shift_stage #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int mon_a;
    bit rand_rdy = 1'b0;
    logic ov_d = 1'b0;
    logic [7:0] sb [256];
    logic [127:0] exp_q [$];
    int lat_q [$];

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] ORD_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ORD_OUT  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Multiplicative-generator walk over GF(2^8) to fill the S-box table
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(4*c+r) -: 8] = sb[b[4*((c+r)%4)+r]];
        return o;
    endfunction

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !ov_d) begin
                if (lat_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL latency: out_valid rose with no block accepted");
                end else begin
                    mon_a = lat_q.pop_front();
                    chk("latency", 128'(cyc - mon_a), 128'(NCYC));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL data: unexpected result %h", out_data);
                end else begin
                    chk("data", out_data, exp_q.pop_front());
                end
            end
        end
        ov_d <= out_valid;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom % 2);
        end
    end

    task automatic send(input logic [127:0] d, input logic [127:0] e, output int acc);
        bit ok;
        ok = 1'b0;
        acc = cyc;
        in_data = d;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                acc = cyc;
                lat_q.push_back(cyc);
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_data = junk();
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL accept: timeout, in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_data = junk();
        end
    endtask

    task automatic wait_out();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            nchk++;
            nerr++;
            $display("FAIL wait_out: out_valid=%b expected 1", out_valid);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        logic [127:0] held;
        logic [127:0] d;

        build_sbox();
        #12;
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_busy", 128'(busy), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = FIPS_IN;
        out_ready = 1'b0;
        in_valid = 1'b0;
        idle(2);
        chk("valid_alone_idle", 128'(busy), 128'(0));
        out_ready = 1'b1;
        send(FIPS_IN, FIPS_OUT, a1);
        idle(NCYC + 3);
        send('0, ZERO_OUT, a1);
        idle(NCYC + 3);
        send(ORD_IN, ORD_OUT, a1);
        idle(NCYC + 3);

        out_ready = 1'b0;
        send(FIPS_IN, FIPS_OUT, a1);
        wait_out();
        held = out_data;
        chk("stall_first", held, FIPS_OUT);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_data = junk();
            @(negedge clk);
            chk("stall_valid", 128'(out_valid), 128'(1));
            chk("stall_data", out_data, held);
            chk("stall_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", 128'(out_valid), 128'(0));
        chk("drain_in_ready", 128'(in_ready), 128'(1));
        chk("drain_busy", 128'(busy), 128'(0));
        idle(2);

        send(FIPS_IN, FIPS_OUT, a1);
        repeat ((NCYC > 2) ? 2 : NCYC - 1) begin
            @(posedge clk);
            #1;
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(0));
        chk("arst_out_data", out_data, '0);
        chk("arst_in_ready", 128'(in_ready), 128'(1));
        chk("arst_busy", 128'(busy), 128'(0));
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(FIPS_IN, FIPS_OUT, a1);
        idle(NCYC + 3);

        send(ORD_IN, ORD_OUT, a1);
        send(FIPS_IN, FIPS_OUT, a2);
        chk("b2b_spacing", 128'(a2 - a1), 128'(NCYC + 2));
        idle(NCYC + 3);

        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            d = junk();
            send(d, model(d), a1);
            idle($urandom_range(0, 3));
        end
        for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
            @(posedge clk);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
